// File: rtl/jtag_tap_oversampled.sv
// -----------------------------------------------------------------------------
// jtag_tap_oversampled
//   IEEE 1149.1 TAP responder (target side). Every flop runs on clk_i. The JTAG
//   pins are brought in through 2-flop synchronisers, and TCK edges are found by
//   oversampling, so no logic is clocked by TCK. The data registers are IDCODE,
//   BYPASS and CONFREG, which holds the SoC test-mode configuration.
//
// Ports
//   clk_i          system clock, must run at 8x TCK or faster
//   rst            asynchronous reset, active high
//   jtag_tck_i     JTAG TCK (asynchronous to clk_i)
//   jtag_trst_ni   JTAG TRST, active low (asynchronous, synchronised here)
//   jtag_tms_i     JTAG TMS
//   jtag_tdi_i     JTAG TDI
//   jtag_tdo_o     JTAG TDO, updated on TCK falling edges
//   jtag_tdo_en_o  TDO output enable, high only in Shift-IR / Shift-DR
//   confreg_o      current CONFREG contents
//   confreg_upd_o  one-clk pulse on every CONFREG update
//   tap_state_o    current TAP state, for debug
// -----------------------------------------------------------------------------
module jtag_tap_oversampled #(
  parameter int unsigned             IR_WIDTH     = 5,
  parameter logic [31:0]             IDCODE_VAL   = 32'h249511C3,
  parameter int unsigned             CONF_WIDTH   = 9,
  parameter logic [CONF_WIDTH-1:0]   CONF_RST     = 9'h000,
  parameter logic [IR_WIDTH-1:0]     INSTR_IDCODE = 5'b00001,
  parameter logic [IR_WIDTH-1:0]     INSTR_CONF   = 5'b00110
) (
  input  logic                  clk_i,
  input  logic                  rst,
  input  logic                  jtag_tck_i,
  input  logic                  jtag_trst_ni,
  input  logic                  jtag_tms_i,
  input  logic                  jtag_tdi_i,
  output logic                  jtag_tdo_o,
  output logic                  jtag_tdo_en_o,
  output logic [CONF_WIDTH-1:0] confreg_o,
  output logic                  confreg_upd_o,
  output logic [3:0]            tap_state_o
);

  typedef enum logic [3:0] {
    ST_TLR    = 4'd0,
    ST_RTI    = 4'd1,
    ST_SEL_DR = 4'd2,
    ST_CAP_DR = 4'd3,
    ST_SH_DR  = 4'd4,
    ST_EX1_DR = 4'd5,
    ST_PA_DR  = 4'd6,
    ST_EX2_DR = 4'd7,
    ST_UPD_DR = 4'd8,
    ST_SEL_IR = 4'd9,
    ST_CAP_IR = 4'd10,
    ST_SH_IR  = 4'd11,
    ST_EX1_IR = 4'd12,
    ST_PA_IR  = 4'd13,
    ST_EX2_IR = 4'd14,
    ST_UPD_IR = 4'd15
  } tap_state_e;

  // Synchroniser chains: index 1 is the synchronised value, and tck index 2 is the edge-detect history.
  logic [2:0] tck_sync_q, tck_sync_d;
  logic [1:0] tms_sync_q, tms_sync_d;
  logic [1:0] tdi_sync_q, tdi_sync_d;
  logic [1:0] trst_sync_q, trst_sync_d;

  tap_state_e                state_q, state_d, state_nxt_s;
  logic [IR_WIDTH-1:0]       ir_q, ir_d;
  logic [IR_WIDTH-1:0]       ir_shift_q, ir_shift_d;
  logic [31:0]               idcode_shift_q, idcode_shift_d;
  logic [CONF_WIDTH-1:0]     conf_shift_q, conf_shift_d;
  logic                      bypass_q, bypass_d;
  logic [CONF_WIDTH-1:0]     confreg_q, confreg_d;
  logic                      confreg_upd_q, confreg_upd_d;
  logic                      tdo_q, tdo_d;
  logic                      tdo_en_q, tdo_en_d;

  logic tck_rise_s, tck_fall_s, tms_s, tdi_s, trst_act_s, ir_col_s, dr_lsb_s;

  assign tck_rise_s = tck_sync_q[1] & ~tck_sync_q[2];
  assign tck_fall_s = ~tck_sync_q[1] & tck_sync_q[2];
  assign tms_s      = tms_sync_q[1];
  assign tdi_s      = tdi_sync_q[1];
  assign trst_act_s = ~trst_sync_q[1];

  // 1149.1 next-state table, evaluated with the synchronised TMS.
  always_comb begin
    state_nxt_s = state_q;
    case (state_q)
      ST_TLR:    state_nxt_s = tms_s ? ST_TLR    : ST_RTI;
      ST_RTI:    state_nxt_s = tms_s ? ST_SEL_DR : ST_RTI;
      ST_SEL_DR: state_nxt_s = tms_s ? ST_SEL_IR : ST_CAP_DR;
      ST_CAP_DR: state_nxt_s = tms_s ? ST_EX1_DR : ST_SH_DR;
      ST_SH_DR:  state_nxt_s = tms_s ? ST_EX1_DR : ST_SH_DR;
      ST_EX1_DR: state_nxt_s = tms_s ? ST_UPD_DR : ST_PA_DR;
      ST_PA_DR:  state_nxt_s = tms_s ? ST_EX2_DR : ST_PA_DR;
      ST_EX2_DR: state_nxt_s = tms_s ? ST_UPD_DR : ST_SH_DR;
      ST_UPD_DR: state_nxt_s = tms_s ? ST_SEL_DR : ST_RTI;
      ST_SEL_IR: state_nxt_s = tms_s ? ST_TLR    : ST_CAP_IR;
      ST_CAP_IR: state_nxt_s = tms_s ? ST_EX1_IR : ST_SH_IR;
      ST_SH_IR:  state_nxt_s = tms_s ? ST_EX1_IR : ST_SH_IR;
      ST_EX1_IR: state_nxt_s = tms_s ? ST_UPD_IR : ST_PA_IR;
      ST_PA_IR:  state_nxt_s = tms_s ? ST_EX2_IR : ST_PA_IR;
      ST_EX2_IR: state_nxt_s = tms_s ? ST_UPD_IR : ST_SH_IR;
      ST_UPD_IR: state_nxt_s = tms_s ? ST_SEL_DR : ST_RTI;
      default:   state_nxt_s = ST_TLR;
    endcase
  end

  // TDO source: the IR column shifts the instruction register, everything else the selected DR.
  always_comb begin
    ir_col_s = 1'b0;
    case (state_q)
      ST_SEL_IR, ST_CAP_IR, ST_SH_IR, ST_EX1_IR,
      ST_PA_IR, ST_EX2_IR, ST_UPD_IR: ir_col_s = 1'b1;
      default:                        ir_col_s = 1'b0;
    endcase
    if (ir_q == INSTR_IDCODE) begin
      dr_lsb_s = idcode_shift_q[0];
    end else if (ir_q == INSTR_CONF) begin
      dr_lsb_s = conf_shift_q[0];
    end else begin
      dr_lsb_s = bypass_q;
    end
  end

  // Datapath: synchronisers, rise actions, fall actions, and the TRST override.
  always_comb begin
    tck_sync_d     = {tck_sync_q[1:0], jtag_tck_i};
    tms_sync_d     = {tms_sync_q[0], jtag_tms_i};
    tdi_sync_d     = {tdi_sync_q[0], jtag_tdi_i};
    trst_sync_d    = {trst_sync_q[0], jtag_trst_ni};
    state_d        = state_q;
    ir_d           = ir_q;
    ir_shift_d     = ir_shift_q;
    idcode_shift_d = idcode_shift_q;
    conf_shift_d   = conf_shift_q;
    bypass_d       = bypass_q;
    confreg_d      = confreg_q;
    confreg_upd_d  = 1'b0;
    tdo_d          = tdo_q;
    tdo_en_d       = tdo_en_q;

    if (trst_act_s) begin
      // TRST wins over any TCK edge seen in the same cycle.
      state_d  = ST_TLR;
      ir_d     = INSTR_IDCODE;
      confreg_d = CONF_RST;
      tdo_d    = 1'b0;
      tdo_en_d = 1'b0;
    end else if (tck_rise_s) begin
      case (state_q)
        ST_CAP_IR: ir_shift_d = {{(IR_WIDTH-2){1'b0}}, 2'b01};
        ST_SH_IR:  ir_shift_d = {tdi_s, ir_shift_q[IR_WIDTH-1:1]};
        ST_CAP_DR: begin
          if (ir_q == INSTR_IDCODE) begin
            idcode_shift_d = IDCODE_VAL;
          end else if (ir_q == INSTR_CONF) begin
            conf_shift_d = confreg_q;
          end else begin
            bypass_d = 1'b0;
          end
        end
        ST_SH_DR: begin
          if (ir_q == INSTR_IDCODE) begin
            idcode_shift_d = {tdi_s, idcode_shift_q[31:1]};
          end else if (ir_q == INSTR_CONF) begin
            conf_shift_d = {tdi_s, conf_shift_q[CONF_WIDTH-1:1]};
          end else begin
            bypass_d = tdi_s;
          end
        end
        default: ;
      endcase
      state_d = state_nxt_s;
      if (state_nxt_s == ST_TLR) begin
        ir_d      = INSTR_IDCODE;
        confreg_d = CONF_RST;
      end else begin
        ir_d = ir_q;
      end
    end else if (tck_fall_s) begin
      tdo_d    = ir_col_s ? ir_shift_q[0] : dr_lsb_s;
      tdo_en_d = (state_q == ST_SH_IR) || (state_q == ST_SH_DR);
      if (state_q == ST_UPD_IR) begin
        ir_d = ir_shift_q;
      end else if ((state_q == ST_UPD_DR) && (ir_q == INSTR_CONF)) begin
        // Every Update-DR under CONF rewrites and pulses, even if the value is unchanged.
        confreg_d     = conf_shift_q;
        confreg_upd_d = 1'b1;
      end else begin
        ir_d = ir_q;
      end
    end else begin
      state_d = state_q;
    end
  end

  // State and datapath registers, cleared by the asynchronous reset.
  always_ff @(posedge clk_i or posedge rst) begin
    if (rst) begin
      tck_sync_q     <= 3'b000;
      tms_sync_q     <= 2'b00;
      tdi_sync_q     <= 2'b00;
      trst_sync_q    <= 2'b00;
      state_q        <= ST_TLR;
      ir_q           <= INSTR_IDCODE;
      ir_shift_q     <= '0;
      idcode_shift_q <= 32'h0000_0000;
      conf_shift_q   <= '0;
      bypass_q       <= 1'b0;
      confreg_q      <= CONF_RST;
      confreg_upd_q  <= 1'b0;
      tdo_q          <= 1'b0;
      tdo_en_q       <= 1'b0;
    end else begin
      tck_sync_q     <= tck_sync_d;
      tms_sync_q     <= tms_sync_d;
      tdi_sync_q     <= tdi_sync_d;
      trst_sync_q    <= trst_sync_d;
      state_q        <= state_d;
      ir_q           <= ir_d;
      ir_shift_q     <= ir_shift_d;
      idcode_shift_q <= idcode_shift_d;
      conf_shift_q   <= conf_shift_d;
      bypass_q       <= bypass_d;
      confreg_q      <= confreg_d;
      confreg_upd_q  <= confreg_upd_d;
      tdo_q          <= tdo_d;
      tdo_en_q       <= tdo_en_d;
    end
  end

  assign jtag_tdo_o    = tdo_q;
  assign jtag_tdo_en_o = tdo_en_q;
  assign confreg_o     = confreg_q;
  assign confreg_upd_o = confreg_upd_q;
  assign tap_state_o   = state_q;

endmodule

// File: tb/tb_jtag_tap_oversampled.sv
// -----------------------------------------------------------------------------
// tb_jtag_tap_oversampled
//   Directed bench for jtag_tap_oversampled. clk_i has a 10 ns period and TCK
//   has a 160 ns period, which is 16 clk cycles per TCK. The host changes TMS
//   and TDI while TCK is low, and it samples TDO just before each TCK rise.
// -----------------------------------------------------------------------------
module tb_jtag_tap_oversampled;

  localparam logic [31:0] IDCODE = 32'h249511C3;

  logic       clk_i = 1'b0;
  logic       rst;
  logic       jtag_tck_i;
  logic       jtag_trst_ni;
  logic       jtag_tms_i;
  logic       jtag_tdi_i;
  logic       jtag_tdo_o;
  logic       jtag_tdo_en_o;
  logic [8:0] confreg_o;
  logic       confreg_upd_o;
  logic [3:0] tap_state_o;

  int n_checks = 0;
  int n_fail   = 0;
  int upd_cnt  = 0;
  int upd_base;
  logic [31:0] dout;
  logic [31:0] irout;

  jtag_tap_oversampled dut (
    .clk_i         (clk_i),
    .rst           (rst),
    .jtag_tck_i    (jtag_tck_i),
    .jtag_trst_ni  (jtag_trst_ni),
    .jtag_tms_i    (jtag_tms_i),
    .jtag_tdi_i    (jtag_tdi_i),
    .jtag_tdo_o    (jtag_tdo_o),
    .jtag_tdo_en_o (jtag_tdo_en_o),
    .confreg_o     (confreg_o),
    .confreg_upd_o (confreg_upd_o),
    .tap_state_o   (tap_state_o)
  );

  // 100 MHz system clock; rising edges fall at 5 mod 10 ns.
  always #5 clk_i = ~clk_i;

  // Counts the clk cycles in which the update pulse is high.
  always @(posedge clk_i) begin
    if (confreg_upd_o === 1'b1) upd_cnt++;
  end

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    if (obs !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp_v);
    end
  endtask

  // One TCK period: set TMS/TDI, sample TDO before the rise, then rise and fall.
  task automatic tck_cycle(input logic tms, input logic tdi, output logic tdo);
    jtag_tms_i = tms;
    jtag_tdi_i = tdi;
    #40;
    tdo = jtag_tdo_o;
    jtag_tck_i = 1'b1;
    #80;
    jtag_tck_i = 1'b0;
    #40;
  endtask

  task automatic step(input logic tms);
    logic unused;
    tck_cycle(tms, 1'b0, unused);
  endtask

  // Shift n bits LSB first. TMS is raised on the last bit when exit_last is set.
  task automatic shift(input int n, input logic [31:0] din, input logic exit_last,
                       output logic [31:0] dout_o);
    logic b;
    dout_o = 32'h0;
    for (int i = 0; i < n; i++) begin
      tck_cycle(exit_last && (i == n - 1), din[i], b);
      dout_o[i] = b;
    end
  endtask

  task automatic enter_shdr();  // from RTI
    step(1'b1); step(1'b0); step(1'b0);
  endtask

  task automatic enter_shir();  // from RTI
    step(1'b1); step(1'b1); step(1'b0); step(1'b0);
  endtask

  task automatic leave_upd();   // from Exit1 through Update to RTI
    step(1'b1); step(1'b0);
  endtask

  task automatic scan_dr(input int n, input logic [31:0] din, output logic [31:0] dout_o);
    enter_shdr();
    shift(n, din, 1'b1, dout_o);
    leave_upd();
  endtask

  task automatic scan_ir(input logic [31:0] din, output logic [31:0] dout_o);
    enter_shir();
    shift(5, din, 1'b1, dout_o);
    leave_upd();
  endtask

  initial begin
    rst          = 1'b0;
    jtag_tck_i   = 1'b0;
    jtag_trst_ni = 1'b1;
    jtag_tms_i   = 1'b1;
    jtag_tdi_i   = 1'b0;
    #2  rst = 1'b1;
    #21;
    // 1: reset values, then five TMS=1 clocks stay in TLR
    check_val("rst_state",   {28'h0, tap_state_o},   32'd0);
    check_val("rst_confreg", {23'h0, confreg_o},     32'h000);
    check_val("rst_tdo_en",  {31'h0, jtag_tdo_en_o}, 32'd0);
    check_val("rst_tdo",     {31'h0, jtag_tdo_o},    32'd0);
    #27 rst = 1'b0;
    #50;
    for (int i = 0; i < 5; i++) step(1'b1);
    check_val("tms1x5_tlr", {28'h0, tap_state_o}, 32'd0);
    step(1'b0);
    check_val("rti_state", {28'h0, tap_state_o}, 32'd1);

    // 2: IDCODE is the default instruction
    enter_shdr();
    check_val("shdr_state",  {28'h0, tap_state_o},   32'd4);
    check_val("shdr_tdo_en", {31'h0, jtag_tdo_en_o}, 32'd1);
    shift(32, 32'h0, 1'b1, dout);
    check_val("ex1dr_state", {28'h0, tap_state_o}, 32'd5);
    leave_upd();
    check_val("idcode_scan", dout, IDCODE);
    check_val("rti_tdo_en",  {31'h0, jtag_tdo_en_o}, 32'd0);

    // 3: BYPASS, one bit of delay
    scan_ir(32'h1F, irout);
    check_val("ir_capture_byp", irout, 32'h01);
    scan_dr(9, 32'h0A5, dout);
    check_val("bypass_first", {31'h0, dout[0]}, 32'd0);
    check_val("bypass_data",  {24'h0, dout[8:1]}, 32'hA5);

    // 4: CONFREG write, then readback of the previous contents
    scan_ir(32'h06, irout);
    check_val("ir_capture_conf", irout, 32'h01);
    upd_base = upd_cnt;
    scan_dr(9, 32'h002, dout);
    check_val("conf_read_rst", dout, 32'h000);
    check_val("conf_val_002",  {23'h0, confreg_o}, 32'h002);
    check_val("conf_upd_once", upd_cnt - upd_base, 32'd1);
    scan_dr(9, 32'h000, dout);
    check_val("conf_readback", dout, 32'h002);
    check_val("conf_val_000",  {23'h0, confreg_o}, 32'h000);
    check_val("conf_upd_twice", upd_cnt - upd_base, 32'd2);
    scan_dr(9, 32'h1A5, dout);
    check_val("conf_val_1a5", {23'h0, confreg_o}, 32'h1A5);

    // 5: TRST asserted mid Shift-DR, after 4 bits
    enter_shdr();
    shift(4, 32'h3, 1'b0, dout);
    check_val("conf_hold_midshift", {23'h0, confreg_o}, 32'h1A5);
    jtag_trst_ni = 1'b0;
    #31;
    check_val("trst_state",   {28'h0, tap_state_o}, 32'd0);
    check_val("trst_confreg", {23'h0, confreg_o},   32'h000);
    #99 jtag_trst_ni = 1'b1;
    #50;
    step(1'b0);
    scan_dr(32, 32'h0, dout);
    check_val("trst_ir_idcode", dout, IDCODE);

    // 6: asynchronous reset asserted during Shift-IR
    scan_ir(32'h06, irout);
    scan_dr(9, 32'h0F0, dout);
    check_val("conf_val_0f0", {23'h0, confreg_o}, 32'h0F0);
    enter_shir();
    shift(2, 32'h3, 1'b0, dout);
    check_val("shir_tdo_en", {31'h0, jtag_tdo_en_o}, 32'd1);
    #20 rst = 1'b1;
    #1;
    check_val("arst_state",   {28'h0, tap_state_o},   32'd0);
    check_val("arst_confreg", {23'h0, confreg_o},     32'h000);
    check_val("arst_tdo_en",  {31'h0, jtag_tdo_en_o}, 32'd0);
    check_val("arst_tdo",     {31'h0, jtag_tdo_o},    32'd0);
    check_val("arst_upd",     {31'h0, confreg_upd_o}, 32'd0);
    #29 rst = 1'b0;
    #50;
    step(1'b0);
    scan_dr(32, 32'h0, dout);
    check_val("arst_idcode_scan", dout, IDCODE);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
